seven_segment_scan_controller: RTL and testbench

Time-multiplexes a 16-bit hex value onto a 4-digit common-anode seven-segment display. It cycles through the digits one at a time. For the active digit it drives the 4-bit nibble into the existing 4-bit hex seven-segment decoder and asserts that digit's active-low select line. New values are double-buffered and take effect only at frame boundaries, which prevents tearing. Optional leading-zero blanking and an anti-ghosting dead time are provided.

---
 rtl/seven_segment_scan_controller.sv | 126 ++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed 4-digit hex scanner for a common-anode seven-segment display.
// Values are double-buffered and swapped in only at frame boundaries to avoid tearing.
module seven_segment_scan_controller #(
    parameter int unsigned DIV_COUNT   = 50000,
    parameter int unsigned DIV_WIDTH   = 16,
    parameter int unsigned DEAD_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        load_i,
    input  logic [15:0] value_i,
    input  logic        lz_blank_i,
    output logic [3:0]  nibble_o,
    output logic [3:0]  digit_sel_o,
    output logic        blank_o,
    output logic        frame_done_o
);

    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0] dead_cnt_q, dead_cnt_d;
    logic [1:0]           digit_idx_q, digit_idx_d;
    logic [15:0]          pending_q, pending_d;
    logic                 pending_valid_q, pending_valid_d;
    logic [15:0]          active_q, active_d;
    logic [3:0]           nibble_q, nibble_d;
    logic [3:0]           digit_sel_q, digit_sel_d;
    logic                 blank_q, blank_d;
    logic                 frame_done_q, frame_done_d;

    logic tick;
    logic frame_end;
    logic lead_zero;
    logic lit;

    assign tick      = enable_i && (div_cnt_q == DIV_WIDTH'(DIV_COUNT - 1));
    assign frame_end = tick && (digit_idx_q == 2'd3);

    // Digit 0 is never suppressed so an all-zero value still shows "0".
    always_comb begin
        lead_zero = 1'b0;
        unique case (digit_idx_q)
            2'd0: lead_zero = 1'b0;
            2'd1: lead_zero = (active_q[15:4] == 12'h000);
            2'd2: lead_zero = (active_q[15:8] == 8'h00);
            2'd3: lead_zero = (active_q[15:12] == 4'h0);
            default: lead_zero = 1'b0;
        endcase
    end

    always_comb begin
        div_cnt_d   = div_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        digit_idx_d = digit_idx_q;
        if (enable_i) begin
            if (tick) begin
                div_cnt_d   = '0;
                digit_idx_d = digit_idx_q + 2'd1;
                dead_cnt_d  = DIV_WIDTH'(DEAD_CYCLES);
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (dead_cnt_q != '0) begin
                    dead_cnt_d = dead_cnt_q - 1'b1;
                end
            end
        end
    end

    // A load landing on the frame boundary bypasses the pending buffer.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        if (frame_end) begin
            if (load_i) begin
                active_d = value_i;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (load_i) begin
            pending_d       = value_i;
            pending_valid_d = 1'b1;
        end
    end

    always_comb begin
        lit          = enable_i && (dead_cnt_q == '0) && !(lz_blank_i && lead_zero);
        nibble_d     = active_q[{digit_idx_q, 2'b00} +: 4];
        digit_sel_d  = lit ? ~(4'b0001 << digit_idx_q) : 4'b1111;
        blank_d      = !lit;
        frame_done_d = frame_end;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q       <= '0;
            dead_cnt_q      <= '0;
            digit_idx_q     <= 2'd0;
            pending_q       <= 16'h0000;
            pending_valid_q <= 1'b0;
            active_q        <= 16'h0000;
            nibble_q        <= 4'h0;
            digit_sel_q     <= 4'b1111;
            blank_q         <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            div_cnt_q       <= div_cnt_d;
            dead_cnt_q      <= dead_cnt_d;
            digit_idx_q     <= digit_idx_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            nibble_q        <= nibble_d;
            digit_sel_q     <= digit_sel_d;
            blank_q         <= blank_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign nibble_o     = nibble_q;
    assign digit_sel_o  = digit_sel_q;
    assign blank_o      = blank_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomized bench for seven_segment_scan_controller, checked against a model driven
// by an enabled-clock count rather than per-register state.
module tb_seven_segment_scan_controller;

    localparam int unsigned DC   = 4;
    localparam int unsigned DW   = 3;
    localparam int unsigned DEAD = 1;
    localparam int unsigned FRAME = 4 * DC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        lz_blank = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  digit_sel;
    logic        blank;
    logic        frame_done;

    seven_segment_scan_controller #(
        .DIV_COUNT  (DC),
        .DIV_WIDTH  (DW),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (enable),
        .load_i      (load),
        .value_i     (value),
        .lz_blank_i  (lz_blank),
        .nibble_o    (nibble),
        .digit_sel_o (digit_sel),
        .blank_o     (blank),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n counts enabled clocks since reset; slot, digit and dead time derive from it.
    int          n = 0;
    logic [15:0] m_active = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_pv = 1'b0;
    int          cyc = 0;
    int          fd_q[$];

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        m_active = 16'h0000;
        m_pend = 16'h0000;
        m_pv = 1'b0;
    endtask

    task automatic cycle(input bit en, input bit ld, input logic [15:0] val, input bit lz);
        int d, p;
        bit lit, bnd, lzb;
        logic [3:0] e_nib, e_sel;
        enable = en;
        load = ld;
        value = val;
        lz_blank = lz;
        d = (n / DC) % 4;
        p = n % DC;
        lzb = lz && (d > 0) && ((m_active >> (4 * d)) == 16'h0000);
        lit = en && !((p < DEAD) && (n >= DC)) && !lzb;
        e_nib = 4'((m_active >> (4 * d)) & 16'h000F);
        e_sel = lit ? ~(4'b0001 << d) : 4'b1111;
        bnd = en && ((n % FRAME) == FRAME - 1);
        if (bnd) begin
            if (ld) m_active = val;
            else if (m_pv) m_active = m_pend;
            m_pv = 1'b0;
        end else if (ld) begin
            m_pend = val;
            m_pv = 1'b1;
        end
        if (en) n++;
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
        check_eq("nibble", 16'(nibble), 16'(e_nib));
        check_eq("digit_sel", 16'(digit_sel), 16'(e_sel));
        check_eq("blank", 16'(blank), 16'(!lit));
        check_eq("frame_done", 16'(frame_done), 16'(bnd));
        check_eq("sel_onehot", 16'($countones(~digit_sel) <= 1), 16'd1);
        if (frame_done) fd_q.push_back(cyc);
    endtask

    initial begin
        int guard;
        logic [15:0] mask;
        bit lz_r;
        // Reset state
        @(posedge clk);
        #1;
        check_eq("rst_nibble", 16'(nibble), 16'h0);
        check_eq("rst_sel", 16'(digit_sel), 16'hF);
        check_eq("rst_blank", 16'(blank), 16'h1);
        check_eq("rst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // 1: free-running scan of zero
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        check_eq("fd_count", 16'(fd_q.size() >= 2), 16'd1);
        if (fd_q.size() >= 2) check_eq("fd_period", 16'(fd_q[1] - fd_q[0]), 16'(FRAME));

        // 2: mid-frame load shows only from the next frame
        cycle(1'b1, 1'b1, 16'h1A3F, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // 3: last load in a frame wins, with leading-zero blanking
        cycle(1'b1, 1'b1, 16'h0005, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b1, 16'h00C0, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // 4: all-zero value still lights digit 0
        cycle(1'b1, 1'b1, 16'h0000, 1'b1);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // 5: disable mid-slot of digit 2
        guard = 0;
        while (!(((n / DC) % 4 == 2) && (n % DC == 1)) && guard < 40) begin
            cycle(1'b1, 1'b0, 16'h0, 1'b0);
            guard++;
        end
        check_eq("reach_digit2", 16'(guard < 40), 16'd1);
        cycle(1'b1, 1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        // Randomized traffic
        lz_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) lz_r = ~lz_r;
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                  16'($urandom) & mask, lz_r);
        end

        // 6: async reset mid-frame with a pending load
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
        cycle(1'b1, 1'b1, 16'h7777, 1'b0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_sel", 16'(digit_sel), 16'hF);
        check_eq("arst_blank", 16'(blank), 16'h1);
        check_eq("arst_nibble", 16'(nibble), 16'h0);
        check_eq("arst_fd", 16'(frame_done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 16'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
